// File: rtl/axil_arbiter_2m.sv
// Two-master to one-slave AXI4-Lite arbiter with round-robin grant and one outstanding transaction.
// Define AXIL_ARB_TIMEOUT_EN to add a watchdog that answers a hung slave with SLVERR.
//  state    | meaning
//  IDLE     | no grant; sample requests, pick winner
//  WR_ADDR  | forward AW and W of the granted master
//  WR_RESP  | route B back to the granted master
//  RD_ADDR  | forward AR of the granted master
//  RD_DATA  | route R back to the granted master
//  ERR_RESP | watchdog expired; answer SLVERR locally (timeout build only)
module axil_arbiter_2m #(
   parameter int ADDR_W         = 32,
   parameter int DATA_W         = 32,
   parameter int TIMEOUT_CYCLES = 1024
) (
   input  logic              aclk,
   input  logic              aresetn,
   input  logic              m0_awvalid,
   output logic              m0_awready,
   input  logic [ADDR_W-1:0] m0_awaddr,
   input  logic [2:0]        m0_awprot,
   input  logic              m0_wvalid,
   output logic              m0_wready,
   input  logic [DATA_W-1:0] m0_wdata,
   input  logic [3:0]        m0_wstrb,
   output logic              m0_bvalid,
   input  logic              m0_bready,
   output logic [1:0]        m0_bresp,
   input  logic              m0_arvalid,
   output logic              m0_arready,
   input  logic [ADDR_W-1:0] m0_araddr,
   input  logic [2:0]        m0_arprot,
   output logic              m0_rvalid,
   input  logic              m0_rready,
   output logic [DATA_W-1:0] m0_rdata,
   output logic [1:0]        m0_rresp,
   input  logic              m1_awvalid,
   output logic              m1_awready,
   input  logic [ADDR_W-1:0] m1_awaddr,
   input  logic [2:0]        m1_awprot,
   input  logic              m1_wvalid,
   output logic              m1_wready,
   input  logic [DATA_W-1:0] m1_wdata,
   input  logic [3:0]        m1_wstrb,
   output logic              m1_bvalid,
   input  logic              m1_bready,
   output logic [1:0]        m1_bresp,
   input  logic              m1_arvalid,
   output logic              m1_arready,
   input  logic [ADDR_W-1:0] m1_araddr,
   input  logic [2:0]        m1_arprot,
   output logic              m1_rvalid,
   input  logic              m1_rready,
   output logic [DATA_W-1:0] m1_rdata,
   output logic [1:0]        m1_rresp,
   output logic              s_awvalid,
   input  logic              s_awready,
   output logic [ADDR_W-1:0] s_awaddr,
   output logic [2:0]        s_awprot,
   output logic              s_wvalid,
   input  logic              s_wready,
   output logic [DATA_W-1:0] s_wdata,
   output logic [3:0]        s_wstrb,
   input  logic              s_bvalid,
   output logic              s_bready,
   input  logic [1:0]        s_bresp,
   output logic              s_arvalid,
   input  logic              s_arready,
   output logic [ADDR_W-1:0] s_araddr,
   output logic [2:0]        s_arprot,
   input  logic              s_rvalid,
   output logic              s_rready,
   input  logic [DATA_W-1:0] s_rdata,
   input  logic [1:0]        s_rresp
);

   if (DATA_W != 32) begin : g_bad_data_w
      $error("axil_arbiter_2m supports DATA_W = 32 only");
   end
   if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout
      $error("axil_arbiter_2m needs TIMEOUT_CYCLES >= 2");
   end

   typedef enum logic [2:0] {
      IDLE, WR_ADDR, WR_RESP, RD_ADDR, RD_DATA
`ifdef AXIL_ARB_TIMEOUT_EN
      , ERR_RESP
`endif
   } state_t;

   state_t state, state_nxt;
   logic   gnt, gnt_nxt, is_wr, is_wr_nxt, last_grant, last_nxt;
   logic   aw_done, aw_done_nxt, w_done, w_done_nxt;

   logic req0, req1, wr0, wr1, win;
   assign wr0  = m0_awvalid & m0_wvalid;
   assign wr1  = m1_awvalid & m1_wvalid;
   assign req0 = m0_arvalid | wr0;
   assign req1 = m1_arvalid | wr1;
   assign win  = (req0 && req1) ? ~last_grant : req1;

   logic g_awvalid, g_wvalid, g_arvalid, g_bready, g_rready;
   assign g_awvalid = gnt ? m1_awvalid : m0_awvalid;
   assign g_wvalid  = gnt ? m1_wvalid  : m0_wvalid;
   assign g_arvalid = gnt ? m1_arvalid : m0_arvalid;
   assign g_bready  = gnt ? m1_bready  : m0_bready;
   assign g_rready  = gnt ? m1_rready  : m0_rready;

   logic              f_awvalid, f_wvalid, f_arvalid, f_bready, f_rready;
   logic              g_awready, g_wready, g_arready, g_bvalid, g_rvalid;
   logic [1:0]        g_bresp, g_rresp;
   logic [DATA_W-1:0] g_rdata;

`ifdef AXIL_ARB_TIMEOUT_EN
   localparam int CNT_W = $clog2(TIMEOUT_CYCLES) + 1;
   logic [CNT_W-1:0] wd_cnt;
`endif

   always_comb begin
      state_nxt   = state;
      gnt_nxt     = gnt;
      is_wr_nxt   = is_wr;
      last_nxt    = last_grant;
      aw_done_nxt = aw_done;
      w_done_nxt  = w_done;
      f_awvalid   = 1'b0;
      f_wvalid    = 1'b0;
      f_arvalid   = 1'b0;
      f_bready    = 1'b0;
      f_rready    = 1'b0;
      g_awready   = 1'b0;
      g_wready    = 1'b0;
      g_arready   = 1'b0;
      g_bvalid    = 1'b0;
      g_rvalid    = 1'b0;
      g_bresp     = 2'b00;
      g_rresp     = 2'b00;
      g_rdata     = '0;
      case (state)
         IDLE: begin
`ifdef AXIL_ARB_TIMEOUT_EN
            // soak up late responses from a transaction the watchdog already closed
            f_bready = 1'b1;
            f_rready = 1'b1;
`endif
            if (req0 || req1) begin
               gnt_nxt     = win;
               last_nxt    = win;
               is_wr_nxt   = win ? wr1 : wr0;
               state_nxt   = (win ? wr1 : wr0) ? WR_ADDR : RD_ADDR;
               aw_done_nxt = 1'b0;
               w_done_nxt  = 1'b0;
            end
         end
         WR_ADDR: begin
            f_awvalid = g_awvalid & ~aw_done;
            f_wvalid  = g_wvalid & ~w_done;
            g_awready = s_awready & ~aw_done;
            g_wready  = s_wready & ~w_done;
            if (f_awvalid && s_awready) aw_done_nxt = 1'b1;
            if (f_wvalid && s_wready)   w_done_nxt  = 1'b1;
            if (aw_done_nxt && w_done_nxt) state_nxt = WR_RESP;
         end
         WR_RESP: begin
            f_bready = g_bready;
            g_bvalid = s_bvalid;
            g_bresp  = s_bresp;
            if (s_bvalid && g_bready) state_nxt = IDLE;
         end
         RD_ADDR: begin
            f_arvalid = g_arvalid;
            g_arready = s_arready;
            if (g_arvalid && s_arready) state_nxt = RD_DATA;
         end
         RD_DATA: begin
            f_rready = g_rready;
            g_rvalid = s_rvalid;
            g_rdata  = s_rdata;
            g_rresp  = s_rresp;
            if (s_rvalid && g_rready) state_nxt = IDLE;
         end
`ifdef AXIL_ARB_TIMEOUT_EN
         ERR_RESP: begin
            if (is_wr) begin
               g_bvalid = 1'b1;
               g_bresp  = 2'b10;
               if (g_bready) state_nxt = IDLE;
            end else begin
               g_rvalid = 1'b1;
               g_rresp  = 2'b10;
               g_rdata  = DATA_W'(32'hDEAD_BEEF);
               if (g_rready) state_nxt = IDLE;
            end
         end
`endif
         default: state_nxt = IDLE;
      endcase
`ifdef AXIL_ARB_TIMEOUT_EN
      // a transaction finishing on the expiry cycle wins over the watchdog
      if (state != IDLE && state != ERR_RESP && state_nxt == state &&
          wd_cnt == CNT_W'(TIMEOUT_CYCLES - 1))
         state_nxt = ERR_RESP;
`endif
   end

   always_ff @(posedge aclk) begin
      if (!aresetn) begin
         state      <= IDLE;
         gnt        <= 1'b0;
         is_wr      <= 1'b0;
         last_grant <= 1'b1;
         aw_done    <= 1'b0;
         w_done     <= 1'b0;
      end else begin
         state      <= state_nxt;
         gnt        <= gnt_nxt;
         is_wr      <= is_wr_nxt;
         last_grant <= last_nxt;
         aw_done    <= aw_done_nxt;
         w_done     <= w_done_nxt;
      end
   end

`ifdef AXIL_ARB_TIMEOUT_EN
   always_ff @(posedge aclk) begin
      if (!aresetn)                                wd_cnt <= '0;
      else if (state_nxt != state)                 wd_cnt <= '0;
      else if (state != IDLE && state != ERR_RESP) wd_cnt <= wd_cnt + 1'b1;
   end
`endif

   logic sel0, sel1;
   assign sel0 = aresetn & ~gnt;
   assign sel1 = aresetn & gnt;

   assign s_awvalid = aresetn & f_awvalid;
   assign s_wvalid  = aresetn & f_wvalid;
   assign s_arvalid = aresetn & f_arvalid;
   assign s_bready  = aresetn & f_bready;
   assign s_rready  = aresetn & f_rready;
   assign s_awaddr  = (aresetn && state == WR_ADDR) ? (gnt ? m1_awaddr : m0_awaddr) : '0;
   assign s_awprot  = (aresetn && state == WR_ADDR) ? (gnt ? m1_awprot : m0_awprot) : '0;
   assign s_wdata   = (aresetn && state == WR_ADDR) ? (gnt ? m1_wdata  : m0_wdata)  : '0;
   assign s_wstrb   = (aresetn && state == WR_ADDR) ? (gnt ? m1_wstrb  : m0_wstrb)  : '0;
   assign s_araddr  = (aresetn && state == RD_ADDR) ? (gnt ? m1_araddr : m0_araddr) : '0;
   assign s_arprot  = (aresetn && state == RD_ADDR) ? (gnt ? m1_arprot : m0_arprot) : '0;

   assign m0_awready = sel0 & g_awready;
   assign m0_wready  = sel0 & g_wready;
   assign m0_arready = sel0 & g_arready;
   assign m0_bvalid  = sel0 & g_bvalid;
   assign m0_rvalid  = sel0 & g_rvalid;
   assign m0_bresp   = sel0 ? g_bresp : 2'b00;
   assign m0_rresp   = sel0 ? g_rresp : 2'b00;
   assign m0_rdata   = sel0 ? g_rdata : '0;
   assign m1_awready = sel1 & g_awready;
   assign m1_wready  = sel1 & g_wready;
   assign m1_arready = sel1 & g_arready;
   assign m1_bvalid  = sel1 & g_bvalid;
   assign m1_rvalid  = sel1 & g_rvalid;
   assign m1_bresp   = sel1 ? g_bresp : 2'b00;
   assign m1_rresp   = sel1 ? g_rresp : 2'b00;
   assign m1_rdata   = sel1 ? g_rdata : '0;

endmodule

// File: tb/tb_axil_arbiter_2m.sv
// Directed bench for axil_arbiter_2m: drives after posedge, samples on negedge.
// Timeout scenario runs only when built with AXIL_ARB_TIMEOUT_EN.
module tb_axil_arbiter_2m;

   logic        aclk, aresetn;
   logic        m0_awvalid, m0_awready, m0_wvalid, m0_wready, m0_bvalid, m0_bready;
   logic        m0_arvalid, m0_arready, m0_rvalid, m0_rready;
   logic [31:0] m0_awaddr, m0_wdata, m0_araddr, m0_rdata;
   logic [2:0]  m0_awprot, m0_arprot;
   logic [3:0]  m0_wstrb;
   logic [1:0]  m0_bresp, m0_rresp;
   logic        m1_awvalid, m1_awready, m1_wvalid, m1_wready, m1_bvalid, m1_bready;
   logic        m1_arvalid, m1_arready, m1_rvalid, m1_rready;
   logic [31:0] m1_awaddr, m1_wdata, m1_araddr, m1_rdata;
   logic [2:0]  m1_awprot, m1_arprot;
   logic [3:0]  m1_wstrb;
   logic [1:0]  m1_bresp, m1_rresp;
   logic        s_awvalid, s_awready, s_wvalid, s_wready, s_bvalid, s_bready;
   logic        s_arvalid, s_arready, s_rvalid, s_rready;
   logic [31:0] s_awaddr, s_wdata, s_araddr, s_rdata;
   logic [2:0]  s_awprot, s_arprot;
   logic [3:0]  s_wstrb;
   logic [1:0]  s_bresp, s_rresp;

   axil_arbiter_2m #(.ADDR_W(32), .DATA_W(32), .TIMEOUT_CYCLES(16)) dut (
      .aclk(aclk), .aresetn(aresetn),
      .m0_awvalid(m0_awvalid), .m0_awready(m0_awready), .m0_awaddr(m0_awaddr), .m0_awprot(m0_awprot),
      .m0_wvalid(m0_wvalid), .m0_wready(m0_wready), .m0_wdata(m0_wdata), .m0_wstrb(m0_wstrb),
      .m0_bvalid(m0_bvalid), .m0_bready(m0_bready), .m0_bresp(m0_bresp),
      .m0_arvalid(m0_arvalid), .m0_arready(m0_arready), .m0_araddr(m0_araddr), .m0_arprot(m0_arprot),
      .m0_rvalid(m0_rvalid), .m0_rready(m0_rready), .m0_rdata(m0_rdata), .m0_rresp(m0_rresp),
      .m1_awvalid(m1_awvalid), .m1_awready(m1_awready), .m1_awaddr(m1_awaddr), .m1_awprot(m1_awprot),
      .m1_wvalid(m1_wvalid), .m1_wready(m1_wready), .m1_wdata(m1_wdata), .m1_wstrb(m1_wstrb),
      .m1_bvalid(m1_bvalid), .m1_bready(m1_bready), .m1_bresp(m1_bresp),
      .m1_arvalid(m1_arvalid), .m1_arready(m1_arready), .m1_araddr(m1_araddr), .m1_arprot(m1_arprot),
      .m1_rvalid(m1_rvalid), .m1_rready(m1_rready), .m1_rdata(m1_rdata), .m1_rresp(m1_rresp),
      .s_awvalid(s_awvalid), .s_awready(s_awready), .s_awaddr(s_awaddr), .s_awprot(s_awprot),
      .s_wvalid(s_wvalid), .s_wready(s_wready), .s_wdata(s_wdata), .s_wstrb(s_wstrb),
      .s_bvalid(s_bvalid), .s_bready(s_bready), .s_bresp(s_bresp),
      .s_arvalid(s_arvalid), .s_arready(s_arready), .s_araddr(s_araddr), .s_arprot(s_arprot),
      .s_rvalid(s_rvalid), .s_rready(s_rready), .s_rdata(s_rdata), .s_rresp(s_rresp)
   );

   int n_checks = 0;
   int n_fail   = 0;
   int cyc      = 0;

   task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   initial begin
      aclk = 1'b0;
      forever #5 aclk = ~aclk;
   end

   initial forever begin
      @(posedge aclk);
      cyc++;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "time limit");
   end

   // slave model: arready/awready always high, wready after slv_w_delay waiting cycles
   logic [31:0] slv_rdata  = 32'h0;
   int          slv_w_delay = 0;
   bit          slv_hang   = 1'b0;
   int          b_cnt      = 0;

   initial begin
      bit ar_hs, r_hs, aw_hs, w_hs, b_hs, w_wait, rst_now, rd_pend, aw_seen, w_seen;
      int w_cnt;
      s_awready = 1'b1; s_arready = 1'b1; s_wready = 1'b0;
      s_bvalid = 1'b0; s_bresp = 2'b00; s_rvalid = 1'b0; s_rresp = 2'b00; s_rdata = '0;
      rd_pend = 0; aw_seen = 0; w_seen = 0; w_cnt = 0;
      forever begin
         @(negedge aclk);
         ar_hs   = s_arvalid && s_arready;
         r_hs    = s_rvalid && s_rready;
         aw_hs   = s_awvalid && s_awready;
         w_hs    = s_wvalid && s_wready;
         b_hs    = s_bvalid && s_bready;
         w_wait  = s_wvalid && !s_wready;
         rst_now = !aresetn;
         @(posedge aclk);
         #1;
         if (rst_now) begin
            s_rvalid = 0; s_bvalid = 0; s_wready = 0;
            rd_pend = 0; aw_seen = 0; w_seen = 0; w_cnt = 0;
         end else begin
            if (r_hs) s_rvalid = 0;
            if (ar_hs) rd_pend = 1;
            if (rd_pend && !slv_hang && !s_rvalid) begin
               s_rvalid = 1; s_rdata = slv_rdata; s_rresp = 2'b00; rd_pend = 0;
            end
            if (b_hs) begin s_bvalid = 0; b_cnt++; end
            if (aw_hs) aw_seen = 1;
            if (w_hs) begin
               w_seen = 1; s_wready = 0; w_cnt = 0;
            end else if (w_wait) begin
               w_cnt++;
               s_wready = (w_cnt >= slv_w_delay);
            end
            if (aw_seen && w_seen && !s_bvalid) begin
               s_bvalid = 1; s_bresp = 2'b00; aw_seen = 0; w_seen = 0;
            end
         end
      end
   end

   bit   mon_m1 = 0;
   int   m1_act = 0;
   logic ar_q[$];

   initial forever begin
      @(negedge aclk);
      if (mon_m1 && (m1_awready || m1_wready || m1_arready || m1_bvalid || m1_rvalid)) m1_act++;
      if (s_arvalid && s_arready) ar_q.push_back(m1_arready);
   end

   task automatic do_reset();
      @(posedge aclk); #1;
      aresetn = 1'b0;
      @(posedge aclk);
      @(posedge aclk); #1;
      aresetn = 1'b1;
   endtask

   initial begin
      int n, aw_c, w_c, b_c, first_aw, first_ar, ar_c;
      bit aw_now, w_now, ar_now, rv;
      aresetn = 1'b0;
      {m0_awvalid, m0_wvalid, m0_arvalid, m1_awvalid, m1_wvalid, m1_arvalid} = '0;
      {m0_awaddr, m0_wdata, m0_araddr, m1_awaddr, m1_wdata, m1_araddr} = '0;
      {m0_awprot, m0_arprot, m1_awprot, m1_arprot} = '0;
      m0_wstrb = 4'hF; m1_wstrb = 4'hF;
      m0_bready = 1; m0_rready = 1; m1_bready = 1; m1_rready = 1;

      // reset values
      repeat (2) @(posedge aclk);
      @(negedge aclk);
      chk("rst_valids", {s_awvalid, s_wvalid, s_arvalid, s_bready, s_rready,
                         m0_awready, m0_wready, m0_arready, m0_bvalid, m0_rvalid,
                         m1_awready, m1_wready, m1_arready, m1_bvalid, m1_rvalid}, 0);
      chk("rst_data", m0_rdata | m1_rdata | {28'h0, m0_rresp, m1_bresp}, 0);
      @(posedge aclk); #1;
      aresetn = 1'b1;
      @(negedge aclk);
      chk("rst_state", 32'(dut.state), 0);
      chk("rst_last_grant", 32'(dut.last_grant), 1);
`ifdef AXIL_ARB_TIMEOUT_EN
      chk("idle_bready", s_bready, 1);
`else
      chk("idle_bready", s_bready, 0);
`endif

      // single m0 read
      mon_m1 = 1; m1_act = 0;
      slv_rdata = 32'h1234_5678;
      @(posedge aclk); #1;
      m0_arvalid = 1; m0_araddr = 32'h0000_0010;
      @(negedge aclk);
      chk("t1_sarvalid_c0", s_arvalid, 0);
      @(negedge aclk);
      chk("t1_sarvalid_c1", s_arvalid, 1);
      chk("t1_araddr", s_araddr, 32'h0000_0010);
      @(posedge aclk); #1;
      m0_arvalid = 0;
      n = 0;
      @(negedge aclk);
      while (!m0_rvalid && n < 20) begin n++; @(negedge aclk); end
      chk("t1_rvalid", m0_rvalid, 1);
      chk("t1_rdata", m0_rdata, 32'h1234_5678);
      chk("t1_rresp", m0_rresp, 0);
      repeat (3) @(negedge aclk);
      chk("t1_m1_quiet", m1_act, 0);
      mon_m1 = 0;

      // both masters read continuously from reset
      do_reset();
      ar_q.delete();
      m0_arvalid = 1; m0_araddr = 32'h100;
      m1_arvalid = 1; m1_araddr = 32'h200;
      n = 0;
      while (ar_q.size() < 4 && n < 100) begin @(negedge aclk); #1; n++; end
      @(posedge aclk); #1;
      m0_arvalid = 0; m1_arvalid = 0;
      chk("t2_count", ar_q.size(), 4);
      for (int i = 0; i < 4; i++)
         chk($sformatf("t2_grant%0d", i), (i < ar_q.size()) ? 32'(ar_q[i]) : 32'hFFFF_FFFF, i % 2);
      repeat (8) @(negedge aclk);

      // m1 write, wready 3 cycles after awready
      b_cnt = 0; slv_w_delay = 3; m1_bready = 0;
      @(posedge aclk); #1;
      m1_awvalid = 1; m1_awaddr = 32'h2000_0004; m1_wvalid = 1; m1_wdata = 32'h0000_A5A5;
      aw_c = -100; w_c = -1; n = 0;
      while (!m1_bvalid && n < 40) begin
         @(negedge aclk); n++;
         aw_now = m1_awvalid && m1_awready;
         w_now  = m1_wvalid && m1_wready;
         if (aw_now) begin aw_c = cyc; chk("t3_awaddr", s_awaddr, 32'h2000_0004); end
         if (w_now)  begin w_c = cyc;  chk("t3_wdata", s_wdata, 32'h0000_A5A5); end
         if (!m1_bvalid) begin
            @(posedge aclk); #1;
            if (aw_now) m1_awvalid = 0;
            if (w_now)  m1_wvalid = 0;
         end
      end
      chk("t3_bvalid", m1_bvalid, 1);
      chk("t3_aw_w_gap", w_c - aw_c, 3);
      @(posedge aclk); #1;
      m1_bready = 1;
      @(negedge aclk);
      chk("t3_bvalid_hold", m1_bvalid, 1);
      chk("t3_bresp", m1_bresp, 0);
      @(posedge aclk); #1;
      m1_bready = 0;
      @(negedge aclk);
      chk("t3_idle", 32'(dut.state), 0);
      chk("t3_bvalid_off", m1_bvalid, 0);
      repeat (3) @(negedge aclk);
      chk("t3_b_once", b_cnt, 1);
      m1_bready = 1;

      // m0 read and write in the same cycle: write goes first
      slv_w_delay = 0;
      @(posedge aclk); #1;
      m0_awvalid = 1; m0_wvalid = 1; m0_arvalid = 1;
      m0_awaddr = 32'h30; m0_wdata = 32'h55; m0_araddr = 32'h34;
      first_aw = -1; first_ar = -1; b_c = -100; rv = 0; n = 0;
      while (!rv && n < 40) begin
         @(negedge aclk); n++;
         if (s_awvalid && first_aw < 0) first_aw = cyc;
         if (s_arvalid && first_ar < 0) first_ar = cyc;
         if (m0_bvalid && m0_bready) b_c = cyc;
         if (m0_rvalid) rv = 1;
         aw_now = m0_awvalid && m0_awready;
         w_now  = m0_wvalid && m0_wready;
         ar_now = m0_arvalid && m0_arready;
         @(posedge aclk); #1;
         if (aw_now) m0_awvalid = 0;
         if (w_now)  m0_wvalid = 0;
         if (ar_now) m0_arvalid = 0;
      end
      chk("t4_write_first", (first_aw >= 0) && (first_ar < 0 || first_aw < first_ar), 1);
      chk("t4_ar_after_b", first_ar - b_c, 2);
      chk("t4_rvalid", rv, 1);
      repeat (3) @(negedge aclk);

      // reset during RD_DATA of an m0 read; next contested grant must be m0
      slv_hang = 1;
      @(posedge aclk); #1;
      m0_arvalid = 1; m0_araddr = 32'h40;
      n = 0;
      @(negedge aclk);
      while (!m0_arready && n < 20) begin n++; @(negedge aclk); end
      @(posedge aclk); #1;
      m0_arvalid = 0;
      @(negedge aclk);
      chk("t5_in_rd_data", 32'(dut.state), 4);
      @(posedge aclk); #1;
      aresetn = 0;
      @(negedge aclk);
      chk("t5_valids_in_rst", {s_awvalid, s_wvalid, s_arvalid, m0_rvalid, m0_bvalid, m1_rvalid, m1_bvalid}, 0);
      @(posedge aclk); #1;
      aresetn = 1;
      @(negedge aclk);
      chk("t5_valids_after", {s_awvalid, s_wvalid, s_arvalid, m0_rvalid, m0_bvalid, m1_rvalid, m1_bvalid}, 0);
      chk("t5_state_idle", 32'(dut.state), 0);
      slv_hang = 0;
      ar_q.delete();
      @(posedge aclk); #1;
      m0_arvalid = 1; m1_arvalid = 1;
      n = 0;
      while (ar_q.size() < 1 && n < 20) begin @(negedge aclk); #1; n++; end
      @(posedge aclk); #1;
      m0_arvalid = 0; m1_arvalid = 0;
      chk("t5_next_grant_m0", (ar_q.size() > 0) ? 32'(ar_q[0]) : 32'hFFFF_FFFF, 0);
      repeat (6) @(negedge aclk);

`ifdef AXIL_ARB_TIMEOUT_EN
      // hung slave read: SLVERR 16 cycles after RD_DATA entry
      slv_hang = 1;
      @(posedge aclk); #1;
      m0_arvalid = 1; m0_araddr = 32'h50;
      n = 0;
      @(negedge aclk);
      while (!m0_arready && n < 20) begin n++; @(negedge aclk); end
      ar_c = cyc;
      @(posedge aclk); #1;
      m0_arvalid = 0;
      n = 0;
      while (!m0_rvalid && n < 40) begin @(negedge aclk); n++; end
      chk("t6_rvalid", m0_rvalid, 1);
      chk("t6_latency", cyc - (ar_c + 1), 16);
      chk("t6_rresp", m0_rresp, 2'b10);
      chk("t6_rdata", m0_rdata, 32'hDEAD_BEEF);
      @(negedge aclk);
      chk("t6_released", m0_rvalid, 0);
      slv_hang = 0;
      repeat (5) @(negedge aclk);
`endif

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
